// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//   Control FSM for the 3x3 conv2d datapath. It loads an IMG_W x IMG_H frame
//   into the image buffer in raster order. It then walks every output position
//   (outer loop), every filter (inner loop) and every kernel tap (row-major),
//   issuing buffer read addresses, weight indices and MAC strobes. Each finished
//   accumulator is offered downstream over a res_valid/res_ready handshake.
//
//   Build option: define SEQ_ZERO_PAD_EN for "same" padding. The window is then
//   centred on (ox,oy), and out-of-image taps raise tap_zero with rd_addr = 0.
//   Without it the convolution is "valid", the window's top-left corner sits at
//   (ox,oy), and tap_zero stays 0.
//
//   Ports
//     clk, rst_n            clock, async active-low reset
//     start, abort          frame start (IDLE only), synchronous abort
//     busy, done            status, done pulses once per completed frame
//     pix_valid/pix_ready   pixel input handshake, pix_we = buffer write enable
//     pix_waddr             buffer write address (raster order)
//     rd_addr, w_idx        buffer read address / weight index for current tap
//     mac_en, acc_clr,      accumulator controls: accumulate, load-first-product,
//     acc_last, tap_zero    last tap, substitute a zero pixel
//     res_valid/res_ready   result handshake, with res_filt / res_pos tags
//
//   State table
//     state  | meaning
//     IDLE   | waiting for start, all outputs 0
//     LOAD   | accepting pixels into the image buffer
//     MAC    | one kernel tap per cycle for current position/filter
//     RES    | result offered downstream, waiting for res_ready
//     DONE   | one-cycle done pulse, then back to IDLE
module conv_window_sequencer #(
    parameter  int IMG_W = 8,
    parameter  int IMG_H = 8,
    parameter  int KSIZE = 3,
    parameter  int NFILT = 2,
`ifdef SEQ_ZERO_PAD_EN
    localparam int OUT_W = IMG_W,
    localparam int OUT_H = IMG_H,
`else
    localparam int OUT_W = IMG_W - KSIZE + 1,
    localparam int OUT_H = IMG_H - KSIZE + 1,
`endif
    localparam int AW  = $clog2(IMG_W * IMG_H),
    localparam int WIW = $clog2(NFILT * KSIZE * KSIZE),
    localparam int PW  = $clog2(OUT_W * OUT_H),
    localparam int FW  = (NFILT > 1) ? $clog2(NFILT) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    input  logic           pix_valid,
    output logic           pix_ready,
    output logic           pix_we,
    output logic [AW-1:0]  pix_waddr,
    output logic [AW-1:0]  rd_addr,
    output logic [WIW-1:0] w_idx,
    output logic           mac_en,
    output logic           acc_clr,
    output logic           acc_last,
    output logic           tap_zero,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [FW-1:0]  res_filt,
    output logic [PW-1:0]  res_pos
);

    localparam int NTAP = KSIZE * KSIZE;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int NPOS = OUT_W * OUT_H;
    localparam int TW   = $clog2(NTAP);
    localparam int KW   = $clog2(KSIZE);
    localparam int OXW  = $clog2(OUT_W);
    localparam int OYW  = $clog2(OUT_H);
`ifdef SEQ_ZERO_PAD_EN
    localparam int PAD  = KSIZE / 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MAC  = 3'd2,
        S_RES  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state, state_n;
    logic [AW-1:0]  waddr, waddr_n;
    logic [TW-1:0]  tap, tap_n;
    logic [KW-1:0]  kx, kx_n, ky, ky_n;
    logic [FW-1:0]  filt, filt_n;
    logic [OXW-1:0] ox, ox_n;
    logic [OYW-1:0] oy, oy_n;
    logic [PW-1:0]  pos, pos_n;

    logic [15:0]    xs, ys, col, row;
    logic           outside;
    logic [AW-1:0]  rd_d;
    logic [WIW-1:0] w_d;

    assign pix_ready = (state == S_LOAD);
    assign pix_we    = pix_ready & pix_valid;
    assign pix_waddr = waddr;

    always_comb begin
        state_n = state;
        waddr_n = waddr;
        tap_n   = tap;
        kx_n    = kx;
        ky_n    = ky;
        filt_n  = filt;
        ox_n    = ox;
        oy_n    = oy;
        pos_n   = pos;

        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_LOAD;
            end
            S_LOAD: begin
                if (pix_valid) begin
                    if (waddr == AW'(NPIX - 1)) begin
                        waddr_n = '0;
                        state_n = S_MAC;
                    end else begin
                        waddr_n = waddr + AW'(1);
                    end
                end
            end
            S_MAC: begin
                if (tap == TW'(NTAP - 1)) begin
                    tap_n   = '0;
                    kx_n    = '0;
                    ky_n    = '0;
                    state_n = S_RES;
                end else begin
                    tap_n = tap + TW'(1);
                    if (kx == KW'(KSIZE - 1)) begin
                        kx_n = '0;
                        ky_n = ky + KW'(1);
                    end else begin
                        kx_n = kx + KW'(1);
                    end
                end
            end
            S_RES: begin
                if (res_ready) begin
                    state_n = S_MAC;
                    if (filt == FW'(NFILT - 1)) begin
                        filt_n = '0;
                        if (pos == PW'(NPOS - 1)) begin
                            pos_n   = '0;
                            ox_n    = '0;
                            oy_n    = '0;
                            state_n = S_DONE;
                        end else begin
                            pos_n = pos + PW'(1);
                            if (ox == OXW'(OUT_W - 1)) begin
                                ox_n = '0;
                                oy_n = oy + OYW'(1);
                            end else begin
                                ox_n = ox + OXW'(1);
                            end
                        end
                    end else begin
                        filt_n = filt + FW'(1);
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (abort) begin
            state_n = S_IDLE;
            waddr_n = '0;
            tap_n   = '0;
            kx_n    = '0;
            ky_n    = '0;
            filt_n  = '0;
            ox_n    = '0;
            oy_n    = '0;
            pos_n   = '0;
        end

        // Tap geometry is decoded from the next-cycle counters so the
        // registered outputs line up with the state they describe.
        xs = 16'(ox_n) + 16'(kx_n);
        ys = 16'(oy_n) + 16'(ky_n);
`ifdef SEQ_ZERO_PAD_EN
        outside = (xs < 16'(PAD)) || (xs >= 16'(IMG_W + PAD)) ||
                  (ys < 16'(PAD)) || (ys >= 16'(IMG_H + PAD));
        col = xs - 16'(PAD);
        row = ys - 16'(PAD);
`else
        outside = 1'b0;
        col = xs;
        row = ys;
`endif
        rd_d = outside ? '0 : AW'(row * 16'(IMG_W) + col);
        w_d  = WIW'(16'(filt_n) * 16'(NTAP) + 16'(tap_n));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            waddr     <= '0;
            tap       <= '0;
            kx        <= '0;
            ky        <= '0;
            filt      <= '0;
            ox        <= '0;
            oy        <= '0;
            pos       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr   <= '0;
            w_idx     <= '0;
            mac_en    <= 1'b0;
            acc_clr   <= 1'b0;
            acc_last  <= 1'b0;
            tap_zero  <= 1'b0;
            res_valid <= 1'b0;
            res_filt  <= '0;
            res_pos   <= '0;
        end else begin
            state     <= state_n;
            waddr     <= waddr_n;
            tap       <= tap_n;
            kx        <= kx_n;
            ky        <= ky_n;
            filt      <= filt_n;
            ox        <= ox_n;
            oy        <= oy_n;
            pos       <= pos_n;
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            mac_en    <= (state_n == S_MAC);
            acc_clr   <= (state_n == S_MAC) && (tap_n == '0);
            acc_last  <= (state_n == S_MAC) && (tap_n == TW'(NTAP - 1));
            tap_zero  <= (state_n == S_MAC) && outside;
            rd_addr   <= (state_n == S_MAC) ? rd_d : '0;
            w_idx     <= (state_n == S_MAC) ? w_d : '0;
            res_valid <= (state_n == S_RES);
            res_filt  <= (state_n == S_RES) ? filt_n : '0;
            res_pos   <= (state_n == S_RES) ? pos_n : '0;
        end
    end

endmodule
